// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with debounce and a 4-digit BCD entry register.
// One pulse per accepted key; digits feed the display multiplexer directly.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col_n,
    output logic [3:0]  row_n,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] digits
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         row_q, row_d;
    logic [3:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic               found_q, found_d;
    logic [3:0]         found_code_q, found_code_d;
    logic [3:0]         cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               key_valid_q, key_valid_d;
    logic [3:0]         key_code_q, key_code_d;
    logic [15:0]        digits_q, digits_d;

    logic               tick, scan_end, hit, scan_key, accept;
    logic [1:0]         col_idx;
    logic [3:0]         scan_code, acc_code;
    logic [CNT_W-1:0]   cnt_inc;

    always_comb begin
        tick     = (div_q == DIV_LAST);
        scan_end = tick && (row_q == 2'd3);
        div_d    = tick ? '0 : div_q + DIV_W'(1);
        row_d    = tick ? row_q + 2'd1 : row_q;
        sync1_d  = col_n;
        sync2_d  = sync1_q;
        row_n    = ~(4'b0001 << row_q);

        // Lowest low column wins within a row
        hit     = (sync2_q != 4'hF);
        col_idx = 2'd0;
        if (!sync2_q[0])      col_idx = 2'd0;
        else if (!sync2_q[1]) col_idx = 2'd1;
        else if (!sync2_q[2]) col_idx = 2'd2;
        else if (!sync2_q[3]) col_idx = 2'd3;

        // Earliest row in the scan wins; found_q carries rows 0..2 into the row-3 tick
        found_d      = found_q;
        found_code_d = found_code_q;
        if (tick && !found_q && hit) begin
            found_d      = 1'b1;
            found_code_d = {row_q, col_idx};
        end
        if (scan_end) found_d = 1'b0;
        scan_key  = found_q || hit;
        scan_code = found_q ? found_code_q : {row_q, col_idx};
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        acc_code = cand_q;
        cnt_inc  = cnt_q + CNT_W'(1);
        if (scan_end) begin
            case (state_q)
                IDLE: begin
                    if (scan_key) begin
                        cand_d = scan_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept   = 1'b1;
                            acc_code = scan_code;
                            cnt_d    = '0;
                            state_d  = PRESSED;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!scan_key) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (scan_code != cand_q) begin
                        cand_d = scan_code;
                        cnt_d  = CNT_W'(1);
                    end else if (cnt_inc == CNT_LAST) begin
                        accept  = 1'b1;
                        cnt_d   = '0;
                        state_d = PRESSED;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!scan_key) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (scan_key) begin
                        cnt_d   = '0;
                        state_d = PRESSED;
                    end else if (cnt_inc >= CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        key_valid_d = accept;
        key_code_d  = accept ? acc_code : key_code_q;
        digits_d    = digits_q;
        if (accept) begin
            if (acc_code <= 4'd9)       digits_d = {digits_q[11:0], acc_code};
            else if (acc_code == 4'hA)  digits_d = 16'h0000;
            else if (acc_code == 4'hB)  digits_d = {4'h0, digits_q[15:4]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            div_q        <= '0;
            row_q        <= 2'd0;
            sync1_q      <= 4'hF;
            sync2_q      <= 4'hF;
            found_q      <= 1'b0;
            found_code_q <= 4'h0;
            cand_q       <= 4'h0;
            cnt_q        <= '0;
            key_valid_q  <= 1'b0;
            key_code_q   <= 4'h0;
            digits_q     <= 16'h0000;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            row_q        <= row_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            found_q      <= found_d;
            found_code_q <= found_code_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
            digits_q     <= digits_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign digits    = digits_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives col_n from row_n and a pressed-key mask;
// expected {key_code, digits} are queued at key press and compared on each key_valid pulse.
module tb_keypad_scanner;
    localparam int SCAN = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] digits;

    logic [15:0] keys;
    logic [19:0] exp_q[$];
    logic [15:0] model_digits;
    int n_vec = 0;
    int n_err = 0;
    int pulses = 0;
    int exp_pulses = 0;
    int cyc = 0;
    int press_cyc = 0;
    int rst_cyc = 0;
    bit lat_on = 1'b0;
    bit rst_lat_on = 1'b0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n),
        .key_valid(key_valid), .key_code(key_code), .digits(digits)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Matrix: a pressed key shorts its column low while its row is driven low
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] next_digits(input logic [15:0] d, input logic [3:0] k);
        if (k <= 4'd9)      return {d[11:0], k};
        else if (k == 4'hA) return 16'h0000;
        else if (k == 4'hB) return {4'h0, d[15:4]};
        else                return d;
    endfunction

    task automatic expect_key(input logic [3:0] k);
        model_digits = next_digits(model_digits, k);
        exp_q.push_back({k, model_digits});
        exp_pulses++;
    endtask

    task automatic hold(input logic [15:0] mask, input int scans);
        keys = mask;
        repeat (scans * SCAN) @(negedge clk);
    endtask

    task automatic tap(input logic [15:0] mask, input logic [3:0] k, input int on, input int off);
        expect_key(k);
        hold(mask, on);
        hold(16'h0, off);
    endtask

    task automatic monitor();
        logic [19:0] e;
        forever begin
            @(negedge clk);
            if (key_valid) begin
                pulses++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("key_code", {28'h0, key_code}, {28'h0, e[19:16]});
                    check("digits", {16'h0, digits}, {16'h0, e[15:0]});
                end
                if (lat_on)
                    check("press_latency_in_40_60", {31'h0, (cyc - press_cyc >= 40) && (cyc - press_cyc <= 60)}, 32'd1);
                if (rst_lat_on)
                    check("post_reset_latency", cyc - rst_cyc, 32'd48);
            end
        end
    endtask

    initial begin
        logic [3:0] er;
        rst = 1'b1;
        keys = 16'h0;
        model_digits = 16'h0000;
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        check("rst_row_n", {28'h0, row_n}, 32'hE);
        check("rst_key_valid", {31'h0, key_valid}, 32'd0);
        check("rst_key_code", {28'h0, key_code}, 32'd0);
        check("rst_digits", {16'h0, digits}, 32'd0);

        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            er = ~(4'b0001 << ((k / 4) % 4));
            check("row_drive", {28'h0, row_n}, {28'h0, er});
            @(negedge clk);
        end
        repeat (2 * SCAN) @(negedge clk);
        check("idle_no_pulse", pulses, 32'd0);

        // Single long press of key 5
        press_cyc = cyc;
        lat_on = 1'b1;
        expect_key(4'd5);
        hold(16'h1 << 5, 10);
        lat_on = 1'b0;
        hold(16'h0, 5);
        check("key5_pulses", pulses, exp_pulses);
        check("key5_digits", {16'h0, digits}, 32'h0005);

        for (int k = 1; k <= 5; k++) tap(16'h1 << k, 4'(k), 4, 4);
        check("seq_digits", {16'h0, digits}, 32'h2345);
        tap(16'h1 << 11, 4'hB, 4, 4);
        check("bs_digits", {16'h0, digits}, 32'h0234);
        tap(16'h1 << 10, 4'hA, 4, 4);
        check("clr_digits", {16'h0, digits}, 32'h0000);
        check("seq_pulses", pulses, exp_pulses);

        // Too-short press, then a release bounce inside one held key
        hold(16'h1 << 2, 2);
        hold(16'h0, 4);
        check("short_press_pulses", pulses, exp_pulses);
        check("short_press_digits", {16'h0, digits}, 32'h0000);
        expect_key(4'd2);
        hold(16'h1 << 2, 3);
        hold(16'h0, 1);
        hold(16'h1 << 2, 3);
        hold(16'h0, 4);
        check("bounce_pulses", pulses, exp_pulses);

        // Two keys at once resolve to the lower code; C..F leave digits alone
        tap((16'h1 << 3) | (16'h1 << 6), 4'd3, 6, 4);
        check("multi_digits", {16'h0, digits}, 32'h0023);
        tap(16'h1 << 13, 4'hD, 4, 4);
        check("keyd_code", {28'h0, key_code}, 32'hD);
        check("keyd_digits", {16'h0, digits}, 32'h0023);
        check("multi_pulses", pulses, exp_pulses);

        // Reset in the middle of a debounce of key 7
        keys = 16'h1 << 7;
        repeat (SCAN + SCAN / 2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_row_n", {28'h0, row_n}, 32'hE);
        check("mid_rst_key_valid", {31'h0, key_valid}, 32'd0);
        check("mid_rst_key_code", {28'h0, key_code}, 32'd0);
        check("mid_rst_digits", {16'h0, digits}, 32'd0);
        model_digits = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rst_cyc = cyc;
        rst_lat_on = 1'b1;
        expect_key(4'd7);
        hold(16'h1 << 7, 6);
        rst_lat_on = 1'b0;
        hold(16'h0, 4);
        check("rst_key7_pulses", pulses, exp_pulses);
        check("rst_key7_digits", {16'h0, digits}, 32'h0007);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart to the 4-digit 7-segment display multiplexer.
- Scans a 4x4 active-low matrix keypad, synchronises and debounces the column inputs, and emits one pulse per accepted key.
- Maintains a 4-digit BCD entry register, `digits`, that feeds the display block's `disp_num` input directly, so the operator can type timer values.

Parameters:
SCAN_DIV, 50000, clocks each row stays driven before advancing (>=4)
DEBOUNCE_SCANS, 4, consecutive full scans a key state must persist to be accepted or released (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
col_n  input  4  keypad columns, active-low, externally pulled up; asynchronous to clk
row_n  output  4  keypad row drive, active-low, one-hot-cold
key_valid  output  1  one-clk pulse on each accepted key press
key_code  output  4  code of last accepted key
digits  output  16  BCD entry: [3:0] newest digit, [15:12] oldest

Behaviour:
- Reset is asynchronous and active-high.
  - All state clears immediately on `rst`.
  - Reset values: row_n=4'b1110 (row 0), key_valid=0, key_code=0, digits=16'h0000.
  - Internal: div counter=0, row index=0, FSM=IDLE, debounce count=0, synchroniser flops=4'b1111.
- Column synchroniser: `col_n` passes through a 2-flop synchroniser before any use.
- Row timing:
  - Div counter counts 0..SCAN_DIV-1.
  - The tick is the cycle where the count equals SCAN_DIV-1.
  - On tick: the row index advances (3 wraps to 0), and row_n = ~(4'b0001 << row index).
  - Synchronised columns are sampled on the tick, i.e. at the end of the row period, before the row changes.
- Key coding:
  - Keypad is labelled 0..F in row-major order: key_code = {row[1:0], col[1:0]}, where col is the index of the low column bit.
  - Within one full scan (rows 0..3), the first pressed key found wins: lowest row, then lowest column.
  - A multi-key press therefore yields the lowest code.
- Scan result is evaluated on the tick of row 3 and is one of:
  - NONE, or
  - KEY(k), where k is the winning code for that scan.
- FSM, evaluated only at scan end:
  - IDLE:
    - NONE -> stay.
    - KEY(k) -> latch candidate=k, cnt=1, go to DEBOUNCE.
    - If DEBOUNCE_SCANS==1, KEY(k) instead accepts immediately (see Accept).
  - DEBOUNCE:
    - KEY(candidate) -> cnt+1; when cnt reaches DEBOUNCE_SCANS, accept and go to PRESSED.
    - KEY(other) -> candidate=other, cnt=1, stay.
    - NONE -> go to IDLE, cnt=0.
  - PRESSED:
    - Any KEY (same or different) -> stay, no new pulse.
    - NONE -> go to RELEASE, cnt=1.
  - RELEASE:
    - NONE -> cnt+1; at DEBOUNCE_SCANS go to IDLE.
    - Any KEY -> go back to PRESSED (bounce on release; no pulse).
    - If DEBOUNCE_SCANS==1, NONE in PRESSED goes straight to IDLE.
- Accept: in the clock cycle after the scan-end tick, all of the following happen together:
  - key_valid=1 for exactly one cycle;
  - key_code=candidate;
  - digits update.
- Digit update on accept:
  - Codes 0..9: digits <= {digits[11:0], code} (oldest digit discarded).
  - Code A: clear, digits <= 16'h0000.
  - Code B: backspace, digits <= {4'h0, digits[15:4]}.
  - Codes C..F: pulse and key_code update only; digits unchanged.
- key_code and digits hold between accepts; key_valid is 0 at all other times.
- Latency: with a key stable from the start of a scan, acceptance comes DEBOUNCE_SCANS scans later, plus 1 clk.
- Scanning never stops, in any state.
- Reset mid-operation: any pending debounce is discarded. A key held through reset must pass a full fresh debounce and produces exactly one pulse after reset deasserts.

Test Plan:
- Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=3 (one scan = 16 clk).
- Key 5 (row1/col1) held 10 scans -> exactly one key_valid pulse ~3 scans after press; key_code=5; digits=16'h0005; no further pulses while held.
- Press/release 1,2,3,4,5, each held 4 scans and released 4 scans -> 5 pulses; digits=16'h2345. Then B -> digits=16'h0234. Then A -> digits=16'h0000.
- Bounce: key 2 held 2 scans then released -> no key_valid; digits unchanged. Key 2 held 3 scans, released 1 scan, held 3 more -> exactly one pulse.
- Keys 3 and 6 pressed simultaneously -> one pulse, key_code=3, digits ends in 3. Also key D -> pulse, key_code=D, digits unchanged.
- Assert rst for 3 clk mid-DEBOUNCE while key 7 is held -> all outputs immediately at reset values, row_n=4'b1110. After deassert, a pulse with key_code=7 occurs only after 3 fresh scans, and only once.
- Row drive check, no keys pressed -> row_n cycles 1110,1101,1011,0111, each for exactly 4 clk; key_valid never asserts.
